// File: rtl/lagarto_pmu_pkg.sv
// Shared constants and types for the Lagarto PMU event-counter bank.
package lagarto_pmu_pkg;

  localparam int PMU_NUM_EVT = 23;

  localparam logic [5:0] PMU_CTRL_ADDR = 6'h00;
  localparam logic [5:0] PMU_OVF_ADDR  = 6'h01;
  localparam logic [5:0] PMU_MASK_ADDR = 6'h02;
  localparam logic [5:0] PMU_IE_ADDR   = 6'h03;
  localparam logic [5:0] PMU_CNT_BASE  = 6'h10;

  localparam int PMU_CTRL_EN_BIT  = 0;
  localparam int PMU_CTRL_CLR_BIT = 1;
  localparam int PMU_CTRL_FRZ_BIT = 2;

  // Field order matches the CTRL bit indices above (en is bit 0).
  typedef struct packed {
    logic frz_ovf;
    logic clr;
    logic en;
  } pmu_ctrl_t;

endpackage

// File: rtl/lagarto_pmu_counter.sv
// One free-running event counter: clear beats write, write beats increment.
module lagarto_pmu_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;

  // Wrap is only reported when the increment actually lands.
  assign ovf_o = inc_i & ~clr_i & ~we_i & (&cnt_q);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (we_i) begin
      cnt_q <= wdata_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lagarto_pmu_counters.sv
// Lagarto PMU counter bank: registered event inputs, per-event counters,
// CTRL/OVF/EVT_MASK/OVF_IE registers, single-outstanding register port and irq.
module lagarto_pmu_counters
  import lagarto_pmu_pkg::*;
#(
  parameter int NUM_EVT = 23,
  parameter int CNT_W   = 64,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_EVT-1:0] pmu_sig_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [ADDR_W-1:0]  reg_addr_i,
  input  logic [DATA_W-1:0]  reg_wdata_i,
  output logic               reg_ack_o,
  output logic [DATA_W-1:0]  reg_rdata_o,
  output logic               irq_o
);

  logic [NUM_EVT-1:0] sig_q, ovf_q, mask_q, ie_q;
  logic [NUM_EVT-1:0] inc, cnt_we, wrap, w1c;
  logic [CNT_W-1:0]   cnt [NUM_EVT];
  pmu_ctrl_t          ctrl_q;
  logic               wr, rd, clr;
  logic [DATA_W-1:0]  rd_data, rdata_q;
  logic               ack_q, irq_q;

  assign wr  = reg_req_i & reg_we_i;
  assign rd  = reg_req_i & ~reg_we_i;
  assign clr = wr && (reg_addr_i == ADDR_W'(PMU_CTRL_ADDR)) && reg_wdata_i[PMU_CTRL_CLR_BIT];
  assign w1c = (wr && (reg_addr_i == ADDR_W'(PMU_OVF_ADDR))) ? reg_wdata_i[NUM_EVT-1:0] : '0;
  assign inc = {NUM_EVT{ctrl_q.en}} & mask_q & sig_q;

  for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_cnt
    assign cnt_we[gi] = wr && (reg_addr_i == ADDR_W'(PMU_CNT_BASE + gi));

    lagarto_pmu_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[gi]),
      .clr_i   (clr),
      .we_i    (cnt_we[gi]),
      .wdata_i (reg_wdata_i[CNT_W-1:0]),
      .cnt_o   (cnt[gi]),
      .ovf_o   (wrap[gi])
    );
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr_i)
      ADDR_W'(PMU_CTRL_ADDR): rd_data = DATA_W'(ctrl_q);
      ADDR_W'(PMU_OVF_ADDR):  rd_data = DATA_W'(ovf_q);
      ADDR_W'(PMU_MASK_ADDR): rd_data = DATA_W'(mask_q);
      ADDR_W'(PMU_IE_ADDR):   rd_data = DATA_W'(ie_q);
      default: begin
        for (int i = 0; i < NUM_EVT; i++) begin
          if (reg_addr_i == ADDR_W'(PMU_CNT_BASE + i)) rd_data = DATA_W'(cnt[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q   <= '0;
      ctrl_q  <= '0;
      ovf_q   <= '0;
      mask_q  <= '1;
      ie_q    <= '0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sig_q <= pmu_sig_i;
      if (wr && (reg_addr_i == ADDR_W'(PMU_CTRL_ADDR))) begin
        ctrl_q.en      <= reg_wdata_i[PMU_CTRL_EN_BIT];
        ctrl_q.frz_ovf <= reg_wdata_i[PMU_CTRL_FRZ_BIT];
      end
      // Freeze-on-overflow overrides a same-edge CTRL write of EN.
      if (ctrl_q.frz_ovf && (|wrap)) ctrl_q.en <= 1'b0;
      ctrl_q.clr <= 1'b0;
      // A new wrap wins over a same-edge write-1-to-clear.
      ovf_q <= clr ? '0 : ((ovf_q & ~w1c) | wrap);
      if (wr && (reg_addr_i == ADDR_W'(PMU_MASK_ADDR))) mask_q <= reg_wdata_i[NUM_EVT-1:0];
      if (wr && (reg_addr_i == ADDR_W'(PMU_IE_ADDR)))   ie_q   <= reg_wdata_i[NUM_EVT-1:0];
      irq_q   <= |(ovf_q & ie_q);
      ack_q   <= reg_req_i;
      rdata_q <= rd ? rd_data : '0;
    end
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Bench for lagarto_pmu_counters: directed corner cases plus randomized event
// bursts, checked against a register-level reference model via a read-data scoreboard.
`timescale 1ns/1ps
module tb_lagarto_pmu_counters;

  localparam int NUM_EVT = 23;
  localparam int CNT_W   = 64;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 6;

  localparam logic [ADDR_W-1:0] A_CTRL = 6'h00;
  localparam logic [ADDR_W-1:0] A_OVF  = 6'h01;
  localparam logic [ADDR_W-1:0] A_MASK = 6'h02;
  localparam logic [ADDR_W-1:0] A_IE   = 6'h03;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NUM_EVT-1:0] pmu_sig_i = '0;
  logic               reg_req_i = 1'b0;
  logic               reg_we_i = 1'b0;
  logic [ADDR_W-1:0]  reg_addr_i = '0;
  logic [DATA_W-1:0]  reg_wdata_i = '0;
  logic               reg_ack_o;
  logic [DATA_W-1:0]  reg_rdata_o;
  logic               irq_o;

  lagarto_pmu_counters #(
    .NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pmu_sig_i   (pmu_sig_i),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_ack_o   (reg_ack_o),
    .reg_rdata_o (reg_rdata_o),
    .irq_o       (irq_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic [CNT_W-1:0]   m_cnt [NUM_EVT];
  logic [NUM_EVT-1:0] m_ovf, m_mask, m_ie;
  logic               m_en, m_frz;

  int n_vec  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_a_q[$];

  function automatic logic [ADDR_W-1:0] cnt_addr(input int i);
    return ADDR_W'(16 + i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = '0;
    m_ovf  = '0;
    m_mask = '1;
    m_ie   = '0;
    m_en   = 1'b0;
    m_frz  = 1'b0;
  endtask

  // One cycle of events seen by the bank.
  task automatic model_cycle(input logic [NUM_EVT-1:0] v);
    logic wrapped;
    wrapped = 1'b0;
    if (m_en) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        if (v[i] && m_mask[i]) begin
          m_cnt[i] = m_cnt[i] + 64'd1;
          if (m_cnt[i] == '0) begin
            m_ovf[i] = 1'b1;
            wrapped  = 1'b1;
          end
        end
      end
    end
    if (wrapped && m_frz) m_en = 1'b0;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k;
    k = int'(a) - 16;
    if (a == A_CTRL) begin
      m_en  = d[0];
      m_frz = d[2];
      if (d[1]) begin
        for (int i = 0; i < NUM_EVT; i++) m_cnt[i] = '0;
        m_ovf = '0;
      end
    end else if (a == A_OVF) begin
      m_ovf = m_ovf & ~d[NUM_EVT-1:0];
    end else if (a == A_MASK) begin
      m_mask = d[NUM_EVT-1:0];
    end else if (a == A_IE) begin
      m_ie = d[NUM_EVT-1:0];
    end else if (k >= 0 && k < NUM_EVT) begin
      m_cnt[k] = d;
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    int k;
    k = int'(a) - 16;
    if (a == A_CTRL) return {61'b0, m_frz, 1'b0, m_en};
    if (a == A_OVF)  return DATA_W'(m_ovf);
    if (a == A_MASK) return DATA_W'(m_mask);
    if (a == A_IE)   return DATA_W'(m_ie);
    if (k >= 0 && k < NUM_EVT) return m_cnt[k];
    return '0;
  endfunction

  function automatic logic exp_irq();
    return |(m_ovf & m_ie);
  endfunction

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every ack pops one expected read-data word.
  always @(negedge clk_i) begin
    logic [DATA_W-1:0] e;
    logic [ADDR_W-1:0] a;
    if (reg_ack_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack with rdata %0h, required no ack", reg_rdata_o);
      end else begin
        e = exp_q.pop_front();
        a = exp_a_q.pop_front();
        if (reg_rdata_o !== e) begin
          n_fail++;
          $display("FAIL rdata@%0h: got %0h, required %0h", a, reg_rdata_o, e);
        end
      end
    end else if (reg_rdata_o !== '0) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_rdata: got %0h, required 0", reg_rdata_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req_start(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] e, input bit push);
    @(negedge clk_i);
    reg_req_i   = 1'b1;
    reg_we_i    = we;
    reg_addr_i  = a;
    reg_wdata_i = d;
    if (push) begin
      exp_q.push_back(e);
      exp_a_q.push_back(a);
    end
  endtask

  task automatic req_end();
    @(negedge clk_i);
    reg_req_i = 1'b0;
    reg_we_i  = 1'b0;
    @(posedge clk_i);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ack_missing: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
      exp_a_q.delete();
    end
  endtask

  task automatic reg_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    model_write(a, d);
    req_start(1'b1, a, d, '0, 1'b1);
    req_end();
  endtask

  task automatic reg_read(input logic [ADDR_W-1:0] a);
    req_start(1'b0, a, '0, exp_read(a), 1'b1);
    req_end();
  endtask

  // Hold v for n cycles, then idle; model counts each cycle.
  task automatic run_events(input logic [NUM_EVT-1:0] v, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      pmu_sig_i = v;
      model_cycle(v);
    end
    @(negedge clk_i);
    pmu_sig_i = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_EVT-1:0] v, rmask;
    int j;

    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ack", DATA_W'(reg_ack_o), '0);
    chk("reset_rdata", reg_rdata_o, '0);
    chk("reset_irq", DATA_W'(irq_o), '0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset values
    reg_read(A_MASK);
    reg_read(A_CTRL);
    reg_read(A_OVF);
    reg_read(A_IE);
    reg_read(cnt_addr(5));
    chk("irq_after_reset", DATA_W'(irq_o), '0);

    // Ten cycles of event 5
    reg_write(A_CTRL, 64'h1);
    run_events(NUM_EVT'(1) << 5, 10);
    reg_write(A_CTRL, 64'h0);
    reg_read(cnt_addr(5));
    reg_read(cnt_addr(0));

    // Two-cycle lag: a read issued the cycle after the event still sees the old count
    reg_write(A_CTRL, 64'h1);
    @(negedge clk_i);
    pmu_sig_i = NUM_EVT'(1) << 5;
    req_start(1'b0, cnt_addr(5), '0, m_cnt[5], 1'b1);
    pmu_sig_i = '0;
    req_end();
    m_cnt[5] = m_cnt[5] + 64'd1;
    reg_read(cnt_addr(5));

    // Wrap of counter 7 with interrupt
    reg_write(cnt_addr(7), 64'hFFFF_FFFF_FFFF_FFFE);
    reg_write(A_IE, 64'h1 << 7);
    reg_write(A_CTRL, 64'h1);
    run_events(NUM_EVT'(1) << 7, 2);
    @(posedge clk_i);
    #1;
    chk("irq_at_wrap_edge", DATA_W'(irq_o), '0);
    @(posedge clk_i);
    #1;
    chk("irq_after_wrap", DATA_W'(irq_o), 64'h1);
    reg_read(cnt_addr(7));
    reg_read(A_OVF);
    reg_write(A_OVF, 64'h1 << 7);
    chk("irq_after_w1c", DATA_W'(irq_o), '0);
    reg_read(A_OVF);

    // Freeze on overflow
    reg_write(A_CTRL, 64'h0);
    reg_write(cnt_addr(3), '1);
    reg_write(cnt_addr(0), 64'h0);
    reg_write(A_CTRL, 64'h5);
    run_events((NUM_EVT'(1) << 3) | NUM_EVT'(1), 4);
    reg_read(A_CTRL);
    reg_read(cnt_addr(0));
    reg_read(cnt_addr(3));
    reg_read(A_OVF);

    // Write vs event on counter 2
    reg_write(A_CTRL, 64'h1);
    @(negedge clk_i);
    pmu_sig_i = NUM_EVT'(1) << 2;
    req_start(1'b1, cnt_addr(2), 64'd100, '0, 1'b1);
    pmu_sig_i = '0;
    req_end();
    m_cnt[2] = 64'd100;
    reg_read(cnt_addr(2));

    // W1C vs new wrap on OVF[9]
    reg_write(cnt_addr(9), '1);
    @(negedge clk_i);
    pmu_sig_i = NUM_EVT'(1) << 9;
    req_start(1'b1, A_OVF, 64'h1 << 9, '0, 1'b1);
    pmu_sig_i = '0;
    req_end();
    m_cnt[9] = '0;
    m_ovf[9] = 1'b1;
    reg_read(A_OVF);
    reg_read(cnt_addr(9));

    // CLR while all events are active
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      pmu_sig_i = '1;
      model_cycle('1);
    end
    model_write(A_CTRL, 64'h2);
    req_start(1'b1, A_CTRL, 64'h2, '0, 1'b1);
    pmu_sig_i = '0;
    req_end();
    for (int i = 0; i < NUM_EVT; i++) reg_read(cnt_addr(i));
    reg_read(A_OVF);
    reg_read(A_CTRL);

    // Randomized bursts
    for (int it = 0; it < 8; it++) begin
      rmask = NUM_EVT'($urandom);
      reg_write(A_MASK, DATA_W'(rmask));
      reg_write(A_IE, DATA_W'(NUM_EVT'($urandom)));
      reg_write(A_OVF, DATA_W'(NUM_EVT'($urandom)));
      j = $urandom_range(0, NUM_EVT - 1);
      reg_write(cnt_addr(j), '1 - 64'($urandom_range(0, 3)));
      reg_write(A_CTRL, 64'h1);
      for (int b = 0; b < 2; b++) begin
        v = NUM_EVT'($urandom);
        run_events(v, $urandom_range(1, 6));
      end
      reg_read(cnt_addr(j));
      for (int r = 0; r < 3; r++) reg_read(cnt_addr($urandom_range(0, NUM_EVT - 1)));
      reg_read(A_OVF);
      reg_read(A_MASK);
      chk("irq_random", DATA_W'(irq_o), DATA_W'(exp_irq()));
    end

    // Unmapped addresses
    reg_read(6'h3F);
    reg_write(6'h3F, '1);
    reg_read(6'h27);
    reg_read(A_MASK);

    // Build up state with a pending irq, then reset under a pending read ack
    reg_write(A_MASK, DATA_W'(~(NUM_EVT'(1) << 20)));
    reg_write(A_IE, '1);
    reg_write(cnt_addr(11), '1);
    reg_write(A_CTRL, 64'h1);
    run_events(NUM_EVT'(1) << 11, 1);
    reg_read(A_OVF);
    reg_read(cnt_addr(11));
    chk("irq_before_reset", DATA_W'(irq_o), DATA_W'(exp_irq()));
    req_start(1'b0, A_MASK, '0, '0, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    reg_req_i = 1'b0;
    reg_we_i  = 1'b0;
    #1;
    chk("reset_drops_ack", DATA_W'(reg_ack_o), '0);
    chk("reset_clears_rdata", reg_rdata_o, '0);
    chk("reset_clears_irq", DATA_W'(irq_o), '0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    reg_read(A_CTRL);
    reg_read(A_OVF);
    reg_read(A_MASK);
    reg_read(A_IE);
    reg_read(cnt_addr(5));
    reg_read(cnt_addr(11));
    chk("irq_after_midreset", DATA_W'(irq_o), '0);

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
